screen_scan_reader: RTL and testbench

Read side of the 128×128 monochrome screen buffer (2048 × 8 bit, 16 bytes per row, bit 7 = leftmost pixel). The sync generator supplies pixel coordinates and syncs. This block turns them into buffer read addresses, fetches one byte per 8 displayed pixels, serialises the bits MSB-first, and drives RGB565 plus syncs delayed to stay pixel-aligned. It sits between the dual-port screen RAM read port and the VGA output pins; the screen control writers own the other port.

---
 rtl/screen_pkg.sv | 25 ++
 rtl/screen_scan_reader_if.sv | 12 +
 rtl/screen_sync_delay.sv | 31 +++
 rtl/screen_scan_reader.sv | 154 +++++++++++++++
 tb/tb_screen_scan_reader.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/screen_pkg.sv
// Screen buffer geometry, colour type and default palette, shared by the
// scan-out reader and the screen_control writers.
package screen_pkg;

    localparam int unsigned SCR_W             = 128;
    localparam int unsigned SCR_H             = 128;
    localparam int unsigned SCR_BYTES_PER_ROW = 16;
    localparam int unsigned SCR_ADDR_W        = 11;
    localparam int unsigned COORD_W           = 11;
    localparam int unsigned COLOR_W           = 16;

    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t FG_DEFAULT        = 16'hFFFF;
    localparam color_t BG_DEFAULT        = 16'h0000;
    localparam color_t OUT_COLOR_DEFAULT = 16'h001F;

    // Video timing flags that travel together through realignment delays.
    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
    } sync_t;

endpackage

// File: rtl/screen_scan_reader_if.sv
// Screen RAM read port: the scan reader is master, the RAM is slave.
interface screen_scan_reader_if;
    import screen_pkg::*;

    logic                  rd_en;
    logic [SCR_ADDR_W-1:0] rd_addr;
    logic [7:0]            rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);

endinterface

// File: rtl/screen_sync_delay.sv
// Two-stage delay for {de, hsync, vsync} with a configurable reset level.
module screen_sync_delay
    import screen_pkg::*;
#(
    parameter sync_t RST_VAL = sync_t'(3'b011)
) (
    input  logic  clk,
    input  logic  rst,
    input  sync_t i_sync,
    output logic  o_de1,
    output sync_t o_sync
);

    sync_t r_stage1;
    sync_t r_stage2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage1 <= RST_VAL;
            r_stage2 <= RST_VAL;
        end else begin
            r_stage1 <= i_sync;
            r_stage2 <= r_stage1;
        end
    end

    // Stage-1 de lets the pixel path gate its colour in step with de_out.
    assign o_de1  = r_stage1.de;
    assign o_sync = r_stage2;

endmodule

// File: rtl/screen_scan_reader.sv
// Screen buffer scan-out: window address generation, byte fetch and MSB-first
// pixel serialiser. Define SCREEN_SCALE2_EN for a 2x2-scaled 256x256 window.
module screen_scan_reader
    import screen_pkg::*;
#(
    parameter logic [COORD_W-1:0] XOFF      = 11'd256,
    parameter logic [COORD_W-1:0] YOFF      = 11'd176,
    parameter color_t             FG        = FG_DEFAULT,
    parameter color_t             BG        = BG_DEFAULT,
    parameter color_t             OUT_COLOR = OUT_COLOR_DEFAULT,
    parameter logic               SYNC_IDLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 de_in,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic [COORD_W-1:0]   x_in,
    input  logic [COORD_W-1:0]   y_in,
    screen_scan_reader_if.master rd_bus,
    output color_t               rgb_out,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 de_out
);

`ifdef SCREEN_SCALE2_EN
    localparam int unsigned SCALE_SH = 1;
`else
    localparam int unsigned SCALE_SH = 0;
`endif
    localparam int unsigned WIN_W = SCR_W << SCALE_SH;
    localparam int unsigned WIN_H = SCR_H << SCALE_SH;
    localparam int unsigned EXT_W = COORD_W + 1;

    logic [EXT_W-1:0]      w_dx;
    logic [EXT_W-1:0]      w_dy;
    logic [6:0]            w_col;
    logic [6:0]            w_row;
    logic                  w_inwin;
    logic                  w_phase_ok;
    logic                  w_load0;
    logic [SCR_ADDR_W-1:0] w_addr;
    logic [SCR_ADDR_W-1:0] r_addr_hold;

    // Offsets below the window wrap to large values, so one compare per axis suffices.
    assign w_dx    = EXT_W'(x_in) - EXT_W'(XOFF);
    assign w_dy    = EXT_W'(y_in) - EXT_W'(YOFF);
    assign w_inwin = de_in && (w_dx < EXT_W'(WIN_W)) && (w_dy < EXT_W'(WIN_H));
    assign w_col   = 7'(w_dx >> SCALE_SH);
    assign w_row   = 7'(w_dy >> SCALE_SH);
    assign w_addr  = {w_row, w_col[6:3]};

`ifdef SCREEN_SCALE2_EN
    assign w_phase_ok = ~x_in[0];
`else
    assign w_phase_ok = 1'b1;
`endif

    assign w_load0        = w_inwin && (w_col[2:0] == 3'd0) && w_phase_ok;
    assign rd_bus.rd_en   = w_load0;
    assign rd_bus.rd_addr = w_load0 ? w_addr : r_addr_hold;

    logic r_inwin1;
    logic r_load1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_hold <= '0;
            r_inwin1    <= 1'b0;
            r_load1     <= 1'b0;
        end else begin
            if (w_load0) begin
                r_addr_hold <= w_addr;
            end
            r_inwin1 <= w_inwin;
            r_load1  <= w_load0;
        end
    end

    sync_t w_sync_in;
    sync_t w_sync_out;
    logic  w_de1;

    assign w_sync_in = '{de: de_in, hsync: hsync_in, vsync: vsync_in};

    screen_sync_delay #(
        .RST_VAL(sync_t'({1'b0, SYNC_IDLE, SYNC_IDLE}))
    ) u_sync_delay (
        .clk    (clk),
        .rst    (rst),
        .i_sync (w_sync_in),
        .o_de1  (w_de1),
        .o_sync (w_sync_out)
    );

    assign de_out    = w_sync_out.de;
    assign hsync_out = w_sync_out.hsync;
    assign vsync_out = w_sync_out.vsync;

    logic [7:0] r_shreg;
    logic [7:0] w_shreg_load;
    logic       w_shift_ok;
    logic       w_bit;
    color_t     r_rgb;

`ifdef SCREEN_SCALE2_EN
    logic r_xodd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xodd1 <= 1'b0;
        end else begin
            r_xodd1 <= x_in[0];
        end
    end

    // Each bit is shown on an even/odd pixel pair, so load unshifted and advance after the odd one.
    assign w_shreg_load = rd_bus.rd_data;
    assign w_shift_ok   = r_xodd1;
`else
    // Bit 7 is consumed on the load pixel, so the register starts at bit 6.
    assign w_shreg_load = {rd_bus.rd_data[6:0], 1'b0};
    assign w_shift_ok   = 1'b1;
`endif

    assign w_bit = r_load1 ? rd_bus.rd_data[7] : r_shreg[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_rgb   <= '0;
        end else begin
            if (r_load1) begin
                r_shreg <= w_shreg_load;
            end else if (r_inwin1 && w_shift_ok) begin
                r_shreg <= {r_shreg[6:0], 1'b0};
            end

            if (!w_de1) begin
                r_rgb <= '0;
            end else if (!r_inwin1) begin
                r_rgb <= OUT_COLOR;
            end else if (w_bit) begin
                r_rgb <= FG;
            end else begin
                r_rgb <= BG;
            end
        end
    end

    assign rgb_out = r_rgb;

endmodule

// File: tb/tb_screen_scan_reader.sv
// Directed bench for screen_scan_reader: two instances (window at 0,0 and at
// the default 256,176) share one sync stream and one buffer image.
module tb_screen_scan_reader;
    import screen_pkg::*;

    localparam color_t C_FG  = 16'hFFFF;
    localparam color_t C_BG  = 16'h0000;
    localparam color_t C_OUT = 16'h001F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        de_in = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [10:0] x_in = '0;
    logic [10:0] y_in = '0;

    always #5 clk = ~clk;

    screen_scan_reader_if bus_a ();
    screen_scan_reader_if bus_b ();

    color_t rgb_a, rgb_b;
    logic   hs_a, vs_a, de_a, hs_b, vs_b, de_b;

    screen_scan_reader #(.XOFF(11'd0), .YOFF(11'd0)) dut_a (
        .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x_in(x_in), .y_in(y_in), .rd_bus(bus_a), .rgb_out(rgb_a),
        .hsync_out(hs_a), .vsync_out(vs_a), .de_out(de_a)
    );

    screen_scan_reader dut_b (
        .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x_in(x_in), .y_in(y_in), .rd_bus(bus_b), .rgb_out(rgb_b),
        .hsync_out(hs_b), .vsync_out(vs_b), .de_out(de_b)
    );

    logic [7:0] mem [0:2047];

    // Synchronous-read RAM model for each instance.
    always @(posedge clk) begin
        if (bus_a.rd_en) bus_a.rd_data <= mem[bus_a.rd_addr];
        if (bus_b.rd_en) bus_b.rd_data <= mem[bus_b.rd_addr];
    end

    color_t      cap_rgb_a [0:2047];
    color_t      cap_rgb_b [0:2047];
    logic        cap_de_a  [0:2047];
    logic        cap_hs_b  [0:2047];
    logic        en_a      [0:2047];
    logic        en_b      [0:2047];
    logic [10:0] addr_a    [0:2047];
    logic [10:0] addr_b    [0:2047];

    int n_tests = 0;
    int n_fail  = 0;
    int rst_at_x = -1;

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    endtask

    // Drive one line segment; outputs for pixel x are captured two cycles later.
    task automatic scan(input int y, input int x0, input int x1, input logic hs);
        for (int i = x0; i <= x1 + 4; i++) begin
            @(posedge clk);
            #1;
            y_in     = 11'(y);
            x_in     = 11'(i);
            de_in    = (i <= x1);
            hsync_in = hs;
            rst      = (i == rst_at_x);
            #1;
            en_a[i]   = bus_a.rd_en;
            en_b[i]   = bus_b.rd_en;
            addr_a[i] = bus_a.rd_addr;
            addr_b[i] = bus_b.rd_addr;
            if (i >= x0 + 2) begin
                cap_rgb_a[i-2] = rgb_a;
                cap_rgb_b[i-2] = rgb_b;
                cap_de_a[i-2]  = de_a;
                cap_hs_b[i-2]  = hs_b;
            end
        end
        @(posedge clk);
        #1;
        de_in    = 1'b0;
        rst      = 1'b0;
        hsync_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_tests++; if (rgb_a !== 16'h0000) begin n_fail++; $display("FAIL reset_rgb_a: got %h want %h", rgb_a, 16'h0000); end
        n_tests++; if (rgb_b !== 16'h0000) begin n_fail++; $display("FAIL reset_rgb_b: got %h want %h", rgb_b, 16'h0000); end
        n_tests++; if (hs_a !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b want 1", hs_a); end
        n_tests++; if (vs_a !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b want 1", vs_a); end
        n_tests++; if (de_a !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b want 0", de_a); end
        n_tests++; if (bus_a.rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", bus_a.rd_en); end
        rst = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (3) @(posedge clk);
    endtask

`ifndef SCREEN_SCALE2_EN
    task automatic test_single_byte();
        int n_rd;
        int n_bad;
        clear_mem();
        mem[(29 << 4) + 2] = 8'h80;
        scan(29, 0, 127, 1'b1);
        n_rd = 0; n_bad = 0;
        for (int x = 0; x < 128; x++) begin
            if (en_a[x]) begin
                n_rd++;
                if ((x % 8) != 0) n_bad++;
            end
        end
        n_tests++; if (n_rd != 16) begin n_fail++; $display("FAIL single_rd_count: got %0d want 16", n_rd); end
        n_tests++; if (n_bad != 0) begin n_fail++; $display("FAIL single_rd_align: got %0d misaligned want 0", n_bad); end
        n_tests++; if (addr_a[16] !== 11'd466) begin n_fail++; $display("FAIL single_rd_addr: got %0d want 466", addr_a[16]); end
        n_tests++; if (cap_rgb_a[15] !== C_BG) begin n_fail++; $display("FAIL single_x15: got %h want %h", cap_rgb_a[15], C_BG); end
        n_tests++; if (cap_rgb_a[16] !== C_FG) begin n_fail++; $display("FAIL single_x16: got %h want %h", cap_rgb_a[16], C_FG); end
        for (int x = 17; x <= 23; x++) begin
            n_tests++; if (cap_rgb_a[x] !== C_BG) begin n_fail++; $display("FAIL single_x%0d: got %h want %h", x, cap_rgb_a[x], C_BG); end
        end
        n_tests++; if (cap_de_a[16] !== 1'b1) begin n_fail++; $display("FAIL single_de_out: got %b want 1", cap_de_a[16]); end
    endtask

    task automatic test_row_ff();
        int n_fg;
        clear_mem();
        for (int k = 0; k < 16; k++) mem[38*16 + k] = 8'hFF;
        scan(38, 0, 130, 1'b1);
        n_fg = 0;
        for (int x = 0; x < 128; x++) if (cap_rgb_a[x] === C_FG) n_fg++;
        n_tests++; if (n_fg != 128) begin n_fail++; $display("FAIL row_ff_count: got %0d want 128", n_fg); end
        n_tests++; if (cap_rgb_a[128] !== C_OUT) begin n_fail++; $display("FAIL row_ff_x128: got %h want %h", cap_rgb_a[128], C_OUT); end
        n_tests++; if (en_a[128] !== 1'b0) begin n_fail++; $display("FAIL row_ff_rd_x128: got %b want 0", en_a[128]); end
    endtask

    task automatic test_window_offset();
        logic [7:0] pat;
        int         n_rd;
        color_t     exp_c;
        clear_mem();
        mem[0]    = 8'hA5;
        mem[2047] = 8'h01;
        pat = 8'hA5;
        scan(176, 250, 270, 1'b1);
        n_tests++; if (cap_rgb_b[255] !== C_OUT) begin n_fail++; $display("FAIL win_x255: got %h want %h", cap_rgb_b[255], C_OUT); end
        n_tests++; if (en_b[255] !== 1'b0) begin n_fail++; $display("FAIL win_rd_x255: got %b want 0", en_b[255]); end
        n_tests++; if (en_b[256] !== 1'b1) begin n_fail++; $display("FAIL win_rd_x256: got %b want 1", en_b[256]); end
        n_tests++; if (addr_b[256] !== 11'd0) begin n_fail++; $display("FAIL win_addr_x256: got %0d want 0", addr_b[256]); end
        for (int k = 0; k < 8; k++) begin
            exp_c = pat[7-k] ? C_FG : C_BG;
            n_tests++; if (cap_rgb_b[256+k] !== exp_c) begin n_fail++; $display("FAIL win_pix%0d: got %h want %h", 256+k, cap_rgb_b[256+k], exp_c); end
        end
        scan(303, 370, 390, 1'b1);
        n_tests++; if (addr_b[376] !== 11'd2047) begin n_fail++; $display("FAIL last_addr: got %0d want 2047", addr_b[376]); end
        n_tests++; if (cap_rgb_b[382] !== C_BG) begin n_fail++; $display("FAIL last_x382: got %h want %h", cap_rgb_b[382], C_BG); end
        n_tests++; if (cap_rgb_b[383] !== C_FG) begin n_fail++; $display("FAIL last_x383: got %h want %h", cap_rgb_b[383], C_FG); end
        n_tests++; if (cap_rgb_b[384] !== C_OUT) begin n_fail++; $display("FAIL last_x384: got %h want %h", cap_rgb_b[384], C_OUT); end
        scan(304, 250, 390, 1'b1);
        n_rd = 0;
        for (int x = 250; x <= 390; x++) if (en_b[x]) n_rd++;
        n_tests++; if (n_rd != 0) begin n_fail++; $display("FAIL below_win_rd: got %0d want 0", n_rd); end
        n_tests++; if (cap_rgb_b[300] !== C_OUT) begin n_fail++; $display("FAIL below_win_x300: got %h want %h", cap_rgb_b[300], C_OUT); end
    endtask

    task automatic test_de_drop();
        clear_mem();
        mem[40*16 + 0] = 8'hF0;
        mem[40*16 + 1] = 8'h0F;
        scan(40, 0, 3, 1'b1);
        n_tests++; if (cap_rgb_a[3] !== C_FG) begin n_fail++; $display("FAIL de_drop_x3: got %h want %h", cap_rgb_a[3], C_FG); end
        n_tests++; if (cap_rgb_a[4] !== 16'h0000) begin n_fail++; $display("FAIL de_drop_x4: got %h want 0000", cap_rgb_a[4]); end
        n_tests++; if (cap_de_a[4] !== 1'b0) begin n_fail++; $display("FAIL de_drop_de: got %b want 0", cap_de_a[4]); end
        scan(40, 0, 15, 1'b1);
        n_tests++; if (cap_rgb_a[0] !== C_FG) begin n_fail++; $display("FAIL newline_x0: got %h want %h", cap_rgb_a[0], C_FG); end
        n_tests++; if (cap_rgb_a[4] !== C_BG) begin n_fail++; $display("FAIL newline_x4: got %h want %h", cap_rgb_a[4], C_BG); end
        n_tests++; if (cap_rgb_a[12] !== C_FG) begin n_fail++; $display("FAIL newline_x12: got %h want %h", cap_rgb_a[12], C_FG); end
    endtask

    task automatic test_mid_reset();
        clear_mem();
        for (int k = 0; k < 16; k++) mem[5*16 + k] = 8'hFF;
        rst_at_x = 259;
        scan(181, 250, 280, 1'b0);
        rst_at_x = -1;
        n_tests++; if (cap_rgb_b[257] !== C_FG) begin n_fail++; $display("FAIL mrst_x257: got %h want %h", cap_rgb_b[257], C_FG); end
        n_tests++; if (cap_rgb_b[258] !== 16'h0000) begin n_fail++; $display("FAIL mrst_x258: got %h want 0000", cap_rgb_b[258]); end
        n_tests++; if (cap_hs_b[258] !== 1'b1) begin n_fail++; $display("FAIL mrst_hs_x258: got %b want 1", cap_hs_b[258]); end
        n_tests++; if (cap_rgb_b[259] !== 16'h0000) begin n_fail++; $display("FAIL mrst_x259: got %h want 0000", cap_rgb_b[259]); end
        for (int x = 260; x <= 263; x++) begin
            n_tests++; if (cap_rgb_b[x] !== C_BG) begin n_fail++; $display("FAIL mrst_x%0d: got %h want %h", x, cap_rgb_b[x], C_BG); end
        end
        n_tests++; if (cap_rgb_b[264] !== C_FG) begin n_fail++; $display("FAIL mrst_x264: got %h want %h", cap_rgb_b[264], C_FG); end
        n_tests++; if (cap_hs_b[260] !== 1'b0) begin n_fail++; $display("FAIL mrst_hs_x260: got %b want 0", cap_hs_b[260]); end
    endtask
`else
    task automatic test_scale();
        int n_rd;
        int n_bad;
        clear_mem();
        mem[0] = 8'h80;
        for (int y = 176; y <= 178; y++) begin
            scan(y, 250, 520, 1'b1);
            n_rd = 0; n_bad = 0;
            for (int x = 250; x <= 520; x++) begin
                if (en_b[x]) begin
                    n_rd++;
                    if (((x - 256) % 16) != 0) n_bad++;
                end
            end
            n_tests++; if (n_rd != 16) begin n_fail++; $display("FAIL scale_rd_count_y%0d: got %0d want 16", y, n_rd); end
            n_tests++; if (n_bad != 0) begin n_fail++; $display("FAIL scale_rd_align_y%0d: got %0d want 0", y, n_bad); end
            if (y < 178) begin
                n_tests++; if (cap_rgb_b[256] !== C_FG) begin n_fail++; $display("FAIL scale_x256_y%0d: got %h want %h", y, cap_rgb_b[256], C_FG); end
                n_tests++; if (cap_rgb_b[257] !== C_FG) begin n_fail++; $display("FAIL scale_x257_y%0d: got %h want %h", y, cap_rgb_b[257], C_FG); end
            end else begin
                n_tests++; if (cap_rgb_b[256] !== C_BG) begin n_fail++; $display("FAIL scale_x256_y%0d: got %h want %h", y, cap_rgb_b[256], C_BG); end
            end
            n_tests++; if (cap_rgb_b[258] !== C_BG) begin n_fail++; $display("FAIL scale_x258_y%0d: got %h want %h", y, cap_rgb_b[258], C_BG); end
            n_tests++; if (cap_rgb_b[255] !== C_OUT) begin n_fail++; $display("FAIL scale_x255_y%0d: got %h want %h", y, cap_rgb_b[255], C_OUT); end
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        clear_mem();
        test_reset();
`ifndef SCREEN_SCALE2_EN
        test_single_byte();
        test_row_ff();
        test_window_offset();
        test_de_drop();
        test_mid_reset();
`else
        test_scale();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
